// File: rtl/lb_uart_tx_pkg.sv
// Shared constants, state type and frame builder for the local-bus UART transmitter.
package lb_uart_tx_pkg;

   localparam int unsigned FRAME_BITS = 11;
   localparam int unsigned BAUD_W     = 20;
   localparam int unsigned BITCNT_W   = 4;

   typedef enum logic {
      IDLE,
      SHIFT
   } tx_state_e;

   // Frame image, LSB first on the line: start, data, optional parity, then stop ones
   // padding out to FRAME_BITS.
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic [7:0] data,
      input logic       bit8,
      input logic       parity_en,
      input logic       odd_n_even
   );
      logic [FRAME_BITS-1:0] frame;
      logic [7:0]            dbits;
      logic                  par;
      dbits    = bit8 ? data : {1'b0, data[6:0]};
      par      = (^dbits) ^ odd_n_even;
      frame    = '1;
      frame[0] = 1'b0;
      frame[7:1] = data[6:0];
      if (bit8) begin
         frame[8] = data[7];
         if (parity_en) frame[9] = par;
      end else if (parity_en) begin
         frame[8] = par;
      end
      return frame;
   endfunction

endpackage

// File: rtl/lb_uart_baud_tick.sv
// Bit-period timer: pulses tick for one cycle at the end of each bit period.
module lb_uart_baud_tick
   import lb_uart_tx_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [BAUD_W-1:0] period,
   input  logic              en,
   output logic              tick
);

   logic [BAUD_W-1:0] cnt;

   // period is never zero here; the caller substitutes 1 for a zero request
   assign tick = en && (cnt == period - BAUD_W'(1));

   // Count cycles within the current bit; restart at each bit boundary or when disabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!en || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + BAUD_W'(1);
      end
   end

endmodule

// File: rtl/lb_uart_tx.sv
// Local-bus UART transmitter: fixed 11-bit frame, configuration latched per write.
module lb_uart_tx
   import lb_uart_tx_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              we,
   input  logic [7:0]        data,
   input  logic              bit8,
   input  logic              parity_en,
   input  logic              odd_n_even,
   input  logic [BAUD_W-1:0] baud_val,
   output logic              txrdy,
   output logic              tx
);

   tx_state_e             state;
   logic [FRAME_BITS-1:0] shreg;
   logic [BITCNT_W-1:0]   bit_cnt;
   logic [BAUD_W-1:0]     baud_q;
   logic                  tick;

   // tx is the shift register's low flop; idle and pad values are all ones
   assign tx = shreg[0];

   lb_uart_baud_tick u_baud_tick (
      .clk    (clk),
      .reset  (reset),
      .period (baud_q),
      .en     (state == SHIFT),
      .tick   (tick)
   );

   // Frame sequencer: load on accepted write, shift once per bit period, return after 11 bits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         txrdy   <= 1'b1;
         shreg   <= '1;
         bit_cnt <= '0;
         baud_q  <= BAUD_W'(1);
      end else if (state == IDLE) begin
         if (cs && we && txrdy) begin
            shreg   <= build_frame(data, bit8, parity_en, odd_n_even);
            baud_q  <= (baud_val == '0) ? BAUD_W'(1) : baud_val;
            bit_cnt <= '0;
            txrdy   <= 1'b0;
            state   <= SHIFT;
         end
      end else if (tick) begin
         if (bit_cnt == BITCNT_W'(FRAME_BITS - 1)) begin
            shreg   <= '1;
            bit_cnt <= '0;
            txrdy   <= 1'b1;
            state   <= IDLE;
         end else begin
            shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
            bit_cnt <= bit_cnt + BITCNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_lb_uart_tx.sv
// Self-checking bench for lb_uart_tx: directed frames plus randomized frames against a bit-list model.
module tb_lb_uart_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs, we;
   logic [7:0]  data;
   logic        bit8, parity_en, odd_n_even;
   logic [19:0] baud_val;
   logic        txrdy, tx;

   int n_checks = 0;
   int n_pass   = 0;

   lb_uart_tx dut (
      .clk        (clk),
      .reset      (reset),
      .cs         (cs),
      .we         (we),
      .data       (data),
      .bit8       (bit8),
      .parity_en  (parity_en),
      .odd_n_even (odd_n_even),
      .baud_val   (baud_val),
      .txrdy      (txrdy),
      .tx         (tx)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   // Expected line bits for one frame, derived from the framing rules
   task automatic model_frame(input logic [7:0] d, input logic b8, pe, odd, output bit q[$]);
      int ones;
      int nb;
      q.delete();
      ones = 0;
      nb = b8 ? 8 : 7;
      q.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         q.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (pe) q.push_back(odd ? (ones % 2 == 0) : (ones % 2 == 1));
      while (q.size() < 11) q.push_back(1'b1);
   endtask

   // Issue a write at the next edge and check every cycle of the resulting frame.
   // noise: random bus activity/config changes during the frame; hold: keep cs/we high after it.
   task automatic do_frame(input logic [7:0] d, input logic b8, pe, odd,
                           input logic [19:0] bv, input bit noise, input bit hold);
      bit q[$];
      int p;
      model_frame(d, b8, pe, odd, q);
      p = (bv == 0) ? 1 : int'(bv);
      cs = 1'b1; we = 1'b1; data = d; bit8 = b8; parity_en = pe; odd_n_even = odd; baud_val = bv;
      @(posedge clk); #1;
      if (!hold) begin cs = 1'b0; we = 1'b0; end
      for (int b = 0; b < 11; b++) begin
         for (int c = 0; c < p; c++) begin
            if (noise) begin
               cs = 1'($urandom); we = 1'($urandom); data = 8'($urandom);
               bit8 = 1'($urandom); parity_en = 1'($urandom); odd_n_even = 1'($urandom);
               baud_val = 20'($urandom_range(0, 7));
            end
            check($sformatf("tx_bit%0d", b), tx, q[b]);
            check("txrdy_busy", txrdy, 1'b0);
            @(posedge clk); #1;
         end
      end
      check("txrdy_end", txrdy, 1'b1);
      check("tx_end", tx, 1'b1);
      cs = hold; we = hold;
   endtask

   initial begin
      bit q[$];
      reset = 1'b0; cs = 1'b1; we = 1'b1; data = 8'hFF; bit8 = 1'b1;
      parity_en = 1'b0; odd_n_even = 1'b0; baud_val = 20'd1;

      // reset held with an active write request
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("rst_tx", tx, 1'b1);
         check("rst_txrdy", txrdy, 1'b1);
      end
      cs = 1'b0; we = 1'b0;
      reset = 1'b1;

      // first write after reset, then the directed frames
      do_frame(8'hA5, 1'b1, 1'b1, 1'b1, 20'd3, 1'b0, 1'b0);
      do_frame(8'hA5, 1'b1, 1'b1, 1'b0, 20'd3, 1'b0, 1'b0);
      do_frame(8'hC3, 1'b0, 1'b0, 1'b0, 20'd2, 1'b0, 1'b0);

      // we without cs is ignored
      cs = 1'b0; we = 1'b1; data = 8'h00;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("nocs_txrdy", txrdy, 1'b1);
         check("nocs_tx", tx, 1'b1);
      end
      we = 1'b0;

      // mid-frame writes and baud changes, baud 0 treated as 1, back-to-back hold
      do_frame(8'h3C, 1'b1, 1'b1, 1'b0, 20'd4, 1'b1, 1'b0);
      do_frame(8'h81, 1'b0, 1'b1, 1'b1, 20'd0, 1'b0, 1'b1);
      do_frame(8'h7E, 1'b1, 1'b0, 1'b0, 20'd1, 1'b0, 1'b0);

      // reset during bit 5
      model_frame(8'h5A, 1'b1, 1'b1, 1'b1, q);
      cs = 1'b1; we = 1'b1; data = 8'h5A; bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b1;
      baud_val = 20'd3;
      @(posedge clk); #1;
      cs = 1'b0; we = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      check("pre_rst_tx_bit5", tx, q[5]);
      check("pre_rst_txrdy", txrdy, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_tx", tx, 1'b1);
      check("async_rst_txrdy", txrdy, 1'b1);
      @(posedge clk); #1;
      reset = 1'b1;
      do_frame(8'h5A, 1'b1, 1'b1, 1'b1, 20'd3, 1'b0, 1'b0);

      // randomized frames
      for (int n = 0; n < 12; n++) begin
         do_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  20'($urandom_range(0, 5)), 1'($urandom), (n < 11) ? 1'($urandom) : 1'b0);
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lb_uart_tx.md
LB_UART_TX -- requirements
Module: lb_UART_Tx

Interface
REQ-001 Parameters: none; all configuration arrives on input ports.
REQ-002 clk  input  1  single rising-edge clock; the only clock in the block.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cs  input  1  chip select; a write requires cs=1.
REQ-005 we  input  1  write enable; a write requires cs=1 and we=1 in the same cycle.
REQ-006 data  input  8  byte to transmit.
REQ-007 bit8  input  1  1 = 8 data bits (data[7:0]); 0 = 7 data bits (data[6:0]).
REQ-008 parity_en  input  1  1 = append a parity bit after the data bits.
REQ-009 odd_n_even  input  1  1 = odd parity; 0 = even parity.
REQ-010 baud_val  input  20  bit period in clk cycles; a value of 0 is treated as 1.
REQ-011 txrdy  output  1  registered; 1 = idle and ready to accept a write.
REQ-012 tx  output  1  registered serial line; idle level is 1.

Function
REQ-013 A write SHALL be accepted on a rising edge where cs=1, we=1 and txrdy=1.
REQ-014 cs/we activity while txrdy=0 SHALL be ignored: no queueing, no corruption of the frame in progress.
REQ-015 On the accepting edge, the block SHALL latch data, bit8, parity_en, odd_n_even and baud_val, and ignore later changes to these inputs until the frame ends.
REQ-016 On the accepting edge, txrdy SHALL go 0 and tx SHALL go 0 (start bit); transmission latency is 0 cycles after the accepting edge.
REQ-017 Frame SHALL always be exactly 11 bit periods, transmitted in this order:
- 1 start bit (0);
- data bits, LSB first (8 or 7 per bit8);
- parity bit, if parity_en=1;
- stop bits (1) filling the remaining periods (1 to 3 stop bits).
REQ-018 Parity SHALL be computed over the transmitted data bits only:
- odd_n_even=1: parity bit makes the total count of ones odd;
- odd_n_even=0: parity bit makes the total count of ones even.
REQ-019 Each bit SHALL be held on tx for exactly max(baud_val,1) clk cycles.
REQ-020 The bit-period counter SHALL restart at every bit boundary.
REQ-021 Implementation: an 11-bit shift register loaded with {stop/pad ones, parity, data, 0}, shifted right one place per bit period, with tx driven from bit 0.
REQ-022 A 4-bit bit counter SHALL run 0..10.
REQ-023 At the edge that ends bit period 10, txrdy SHALL return to 1 and tx SHALL stay 1.
REQ-024 A write is accepted from the next edge after txrdy returns to 1 onward.
REQ-025 Back-to-back frames: a write held asserted SHALL be accepted on the first edge after txrdy rises, giving no idle gap beyond that one cycle.
REQ-026 States: IDLE (txrdy=1, tx=1) -> SHIFT on an accepted write; SHIFT -> IDLE after 11 bit periods.
REQ-027 No other states SHALL exist.

Reset
REQ-028 While reset=0, asynchronously:
- tx=1, txrdy=1;
- counters and shift register cleared to their idle values;
- state = IDLE.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with no partial completion.
REQ-030 After reset is released, the first write SHALL be accepted on the first qualifying edge.

Structure
REQ-031 Shared package SHALL hold:
- FRAME_BITS = 11;
- baud-count width = 20;
- bit-counter width = 4;
- the state enumeration (IDLE, SHIFT).
REQ-032 One sub-module SHALL exist: lb_uart_baud_tick.
- Inputs: latched baud period, enable.
- Output: one-cycle tick at the end of each bit period.
- Counter clears when the enable is low.
REQ-033 Total RTL is expected to be 120-400 lines.

Verification
REQ-034 Reset held low with cs=1, we=1 -> tx=1, txrdy=1 throughout; no frame is started.
REQ-035 data=0xA5, bit8=1, parity_en=1, odd_n_even=1, baud_val=3, single cs&we pulse ->
- tx sequence 0,1,0,1,0,0,1,0,1,1(parity),1(stop), each bit 3 clocks;
- txrdy low for 33 clocks, then high.
REQ-036 Same as REQ-035 but odd_n_even=0 -> parity bit = 0; every other bit unchanged.
REQ-037 data=0xC3, bit8=0, parity_en=0, baud_val=2 -> tx = 0,1,1,0,0,0,0,1 then 3 stop bits of 1, each bit 2 clocks.
REQ-038 we=1 with cs=0 -> ignored, txrdy stays 1.
REQ-039 Second write mid-frame -> ignored, first frame unchanged.
REQ-040 baud_val changed mid-frame -> timing unchanged.
REQ-041 Reset asserted at bit 5 of a frame -> tx=1 and txrdy=1 immediately; after release, a new write sends a complete, correct frame.
